// File: rtl/hw_cell_free_pkg.sv
// ---------------------------------------------------------------------------
// hw_cell_free_pkg
// Shared definitions for the cell-release block: the ceiling-log2 helper used
// to size port indices, and the bit positions inside the sticky error vector.
// No ports (package).
// ---------------------------------------------------------------------------
package hw_cell_free_pkg;

   // Bit positions inside o_err
   localparam int ERR_OVF = 2;
   localparam int ERR_DBL = 1;
   localparam int ERR_ZMW = 0;

   // Ceiling log2; returns 0 for values of 0 or 1
   function automatic int clogb(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hw_cell_free_rr_arb.sv
// ---------------------------------------------------------------------------
// hw_cell_free_rr_arb
// Round-robin arbiter for the per-port release requests. Scans the request
// vector starting at the pointer and grants the first requester found; the
// pointer then moves to one past the winner so every port waits at most
// MWIDTH-1 cycles.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (grant forced low while low)
//   req_i    in   MWIDTH request vector
//   grant_o  out  MWIDTH one-hot grant, combinational from req_i
// ---------------------------------------------------------------------------
module hw_cell_free_rr_arb
   import hw_cell_free_pkg::*;
#(
   parameter int MWIDTH     = 4,
   parameter int LOG_MWIDTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MWIDTH-1:0] req_i,
   output logic [MWIDTH-1:0] grant_o
);

   // Keep the pointer at least one bit wide even for a single-port build
   localparam int PTR_W = (LOG_MWIDTH < 1) ? 1 : LOG_MWIDTH;

   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  ptr_d;
   logic [MWIDTH-1:0] grant;
   logic              found;
   int                grantIdx;
   int                scanIdx;

   // Priority scan beginning at the pointer, wrapping around the port range
   always_comb begin
      grant    = '0;
      found    = 1'b0;
      grantIdx = 0;
      scanIdx  = 0;
      for (int i = 0; i < MWIDTH; i++) begin
         scanIdx = (int'(ptr_q) + i) % MWIDTH;
         if (!found && req_i[scanIdx]) begin
            found           = 1'b1;
            grant[scanIdx]  = 1'b1;
            grantIdx        = scanIdx;
         end
      end
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (grantIdx == MWIDTH - 1) ? '0 : PTR_W'(grantIdx + 1);
      end
   end

   assign grant_o = rst_n ? grant : '0;

   // Pointer register; unchanged when nobody requests
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/hw_cell_free.sv
// ---------------------------------------------------------------------------
// hw_cell_free
// Release side of the shared-memory cell allocator. Remembers the multicast
// mask of every written cell, clears one bit per egress "read done" report,
// and once a cell's mask empties pushes its address into the free FIFO that
// the allocator pops, pulsing o_bf_free_flag for the available-cell counter.
//
// Optional feature macro: HW_CELL_FREE_ERR_CHK_EN enables the sticky error
// vector; without it o_err is tied to zero.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_gsm_wr_en       allocator wrote a cell this cycle
//   i_gsm_cell_addr   address of the written cell
//   i_gsm_multicast   destination port mask of the written cell
//   i_rd_done         per-port release request, held until acked
//   i_rd_addr         per-port released address, port p at [p*AWIDTH +: AWIDTH]
//   o_rd_ack          one-hot grant, same cycle
//   i_hmp_rd          allocator pops the free FIFO
//   o_hmp_valid       free FIFO non-empty
//   o_hmp_addr        free FIFO head (first-word-fall-through)
//   o_bf_free_flag    one-cycle pulse per freed cell
//   o_err             sticky {overflow, double_free, zero_mask_wr}
// ---------------------------------------------------------------------------
module hw_cell_free
   import hw_cell_free_pkg::*;
#(
   parameter int MWIDTH = 4,
   parameter int AWIDTH = 7
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_gsm_wr_en,
   input  logic [AWIDTH-1:0]        i_gsm_cell_addr,
   input  logic [MWIDTH-1:0]        i_gsm_multicast,
   input  logic [MWIDTH-1:0]        i_rd_done,
   input  logic [MWIDTH*AWIDTH-1:0] i_rd_addr,
   output logic [MWIDTH-1:0]        o_rd_ack,
   input  logic                     i_hmp_rd,
   output logic                     o_hmp_valid,
   output logic [AWIDTH-1:0]        o_hmp_addr,
   output logic                     o_bf_free_flag,
   output logic [2:0]               o_err
);

   localparam int LOG_MWIDTH = clogb(MWIDTH);
   localparam int DEPTH      = 2 ** AWIDTH;

   logic [MWIDTH-1:0] mask_q [DEPTH];
   logic [AWIDTH-1:0] fifoMem_q [DEPTH];
   logic [AWIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [AWIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [AWIDTH:0]   count_q, count_d;
   logic              flag_q;

   logic              relValid;
   logic [AWIDTH-1:0] relAddr;
   logic [MWIDTH-1:0] oldMask;
   logic [MWIDTH-1:0] newMask;
   logic              bitSet;
   logic              collide;
   logic              relApply;
   logic              pushReq;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              pushOk;
   logic              popOk;

   hw_cell_free_rr_arb #(
      .MWIDTH     (MWIDTH),
      .LOG_MWIDTH (LOG_MWIDTH)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (i_rd_done),
      .grant_o (o_rd_ack)
   );

   // Select the granted port's address; the one-hot ack doubles as the bit
   // to clear, so no port index is needed. A release colliding with a write
   // to the same cell is dropped because the fresh mask must win.
   always_comb begin
      relAddr = '0;
      for (int p = 0; p < MWIDTH; p++) begin
         if (o_rd_ack[p]) begin
            relAddr = i_rd_addr[p*AWIDTH +: AWIDTH];
         end
      end
      relValid  = |o_rd_ack;
      oldMask   = mask_q[relAddr];
      newMask   = oldMask & ~o_rd_ack;
      bitSet    = |(oldMask & o_rd_ack);
      collide   = relValid && i_gsm_wr_en && (i_gsm_cell_addr == relAddr);
      relApply  = relValid && !collide && bitSet;
      pushReq   = relApply && (newMask == '0);
      fifoFull  = (count_q == (AWIDTH+1)'(DEPTH));
      fifoEmpty = (count_q == '0);
      pushOk    = pushReq && !fifoFull;
      popOk     = i_hmp_rd && !fifoEmpty;
   end

   // Mask register file; a write and a release never target the same entry
   // here because collisions were filtered out above
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mask_q[i] <= '0;
         end
      end else begin
         if (relApply) begin
            mask_q[relAddr] <= newMask;
         end
         if (i_gsm_wr_en) begin
            mask_q[i_gsm_cell_addr] <= i_gsm_multicast;
         end
      end
   end

   // FIFO pointer and occupancy next-state; pointers wrap naturally
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (pushOk) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (popOk) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({pushOk, popOk})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage needs no reset: the head is masked while empty
   always_ff @(posedge clk) begin
      if (pushOk) begin
         fifoMem_q[wrPtr_q] <= relAddr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         flag_q  <= pushOk;
      end
   end

   assign o_hmp_valid    = !fifoEmpty;
   assign o_hmp_addr     = fifoEmpty ? '0 : fifoMem_q[rdPtr_q];
   assign o_bf_free_flag = flag_q;

`ifdef HW_CELL_FREE_ERR_CHK_EN
   logic [2:0] err_q, err_d;

   // Sticky error accumulation; a collided release counts as a double free
   always_comb begin
      err_d = err_q;
      if (pushReq && fifoFull) begin
         err_d[ERR_OVF] = 1'b1;
      end
      if (relValid && (collide || !bitSet)) begin
         err_d[ERR_DBL] = 1'b1;
      end
      if (i_gsm_wr_en && (i_gsm_multicast == '0)) begin
         err_d[ERR_ZMW] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_err = err_q;
`else
   assign o_err = '0;
`endif

endmodule

// File: tb/tb_hw_cell_free.sv
// ---------------------------------------------------------------------------
// tb_hw_cell_free
// Directed self-checking bench for hw_cell_free. Inputs change on the falling
// edge; combinational acks are sampled 1 time unit later and registered
// outputs on the following falling edge.
// ---------------------------------------------------------------------------
module tb_hw_cell_free;

`ifdef HW_CELL_FREE_ERR_CHK_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic        clk;
   logic        rstN;
   logic        wrEn;
   logic [6:0]  cellAddr;
   logic [3:0]  multicast;
   logic [3:0]  rdDone;
   logic [27:0] rdAddr;
   logic [3:0]  rdAck;
   logic        hmpRd;
   logic        hmpValid;
   logic [6:0]  hmpAddr;
   logic        bfFlag;
   logic [2:0]  err;

   int total;
   int bad;

   hw_cell_free #(.MWIDTH(4), .AWIDTH(7)) dut (
      .clk             (clk),
      .rst_n           (rstN),
      .i_gsm_wr_en     (wrEn),
      .i_gsm_cell_addr (cellAddr),
      .i_gsm_multicast (multicast),
      .i_rd_done       (rdDone),
      .i_rd_addr       (rdAddr),
      .o_rd_ack        (rdAck),
      .i_hmp_rd        (hmpRd),
      .o_hmp_valid     (hmpValid),
      .o_hmp_addr      (hmpAddr),
      .o_bf_free_flag  (bfFlag),
      .o_err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and return on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      wrEn      = 1'b0;
      cellAddr  = '0;
      multicast = '0;
      rdDone    = '0;
      rdAddr    = '0;
      hmpRd     = 1'b0;
   endtask

   task automatic do_reset();
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
   endtask

   task automatic do_write(input logic [6:0] a, input logic [3:0] m);
      wrEn      = 1'b1;
      cellAddr  = a;
      multicast = m;
      tick();
      wrEn      = 1'b0;
   endtask

   task automatic set_release(input int port, input logic [6:0] a);
      rdDone[port]          = 1'b1;
      rdAddr[port*7 +: 7]   = a;
   endtask

   task automatic test_reset();
      idle();
      rstN   = 1'b0;
      rdDone = 4'b1111;
      #1;
      total++;
      if (rdAck !== 4'b0000) begin
         bad++; $display("[TB] FAIL reset_ack: got %b expected %b", rdAck, 4'b0000);
      end
      tick();
      tick();
      rdDone = '0;
      rstN   = 1'b1;
      total++;
      if (hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_valid: got %b expected 0", hmpValid);
      end
      total++;
      if (hmpAddr !== 7'd0) begin
         bad++; $display("[TB] FAIL reset_addr: got %0d expected 0", hmpAddr);
      end
      total++;
      if (bfFlag !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_flag: got %b expected 0", bfFlag);
      end
      total++;
      if (err !== 3'b000) begin
         bad++; $display("[TB] FAIL reset_err: got %b expected 000", err);
      end
   endtask

   task automatic test_multicast_release();
      do_write(7'd5, 4'b0101);
      set_release(0, 7'd5);
      #1;
      total++;
      if (rdAck !== 4'b0001) begin
         bad++; $display("[TB] FAIL mc_ack0: got %b expected 0001", rdAck);
      end
      tick();
      rdDone = '0;
      total++;
      if (bfFlag !== 1'b0 || hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL mc_partial: got flag=%b valid=%b expected 0 0", bfFlag, hmpValid);
      end
      set_release(2, 7'd5);
      #1;
      total++;
      if (rdAck !== 4'b0100) begin
         bad++; $display("[TB] FAIL mc_ack2: got %b expected 0100", rdAck);
      end
      tick();
      rdDone = '0;
      total++;
      if (bfFlag !== 1'b1 || hmpValid !== 1'b1 || hmpAddr !== 7'd5) begin
         bad++; $display("[TB] FAIL mc_free: got flag=%b valid=%b addr=%0d expected 1 1 5", bfFlag, hmpValid, hmpAddr);
      end
      tick();
      total++;
      if (bfFlag !== 1'b0) begin
         bad++; $display("[TB] FAIL mc_pulse: got %b expected 0", bfFlag);
      end
      hmpRd = 1'b1;
      tick();
      hmpRd = 1'b0;
      total++;
      if (hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL mc_pop: got valid=%b expected 0", hmpValid);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] expAck;
      do_reset();
      for (int p = 0; p < 4; p++) begin
         expAck = 4'b0001 << p;
         do_write(7'(10 + p), expAck);
      end
      for (int p = 0; p < 4; p++) begin
         set_release(p, 7'(10 + p));
      end
      for (int k = 0; k < 4; k++) begin
         expAck = 4'b0001 << k;
         #1;
         total++;
         if (rdAck !== expAck) begin
            bad++; $display("[TB] FAIL rr_ack%0d: got %b expected %b", k, rdAck, expAck);
         end
         tick();
         rdDone[k] = 1'b0;
         total++;
         if (bfFlag !== 1'b1) begin
            bad++; $display("[TB] FAIL rr_flag%0d: got %b expected 1", k, bfFlag);
         end
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (hmpValid !== 1'b1 || hmpAddr !== 7'(10 + k)) begin
            bad++; $display("[TB] FAIL rr_order%0d: got valid=%b addr=%0d expected 1 %0d", k, hmpValid, hmpAddr, 10 + k);
         end
         hmpRd = 1'b1;
         tick();
      end
      hmpRd = 1'b0;
      total++;
      if (hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL rr_drain: got valid=%b expected 0", hmpValid);
      end
   endtask

   task automatic test_push_pop_empty();
      do_write(7'd30, 4'b0010);
      set_release(1, 7'd30);
      hmpRd = 1'b1;
      #1;
      total++;
      if (rdAck !== 4'b0010) begin
         bad++; $display("[TB] FAIL ppe_ack: got %b expected 0010", rdAck);
      end
      tick();
      rdDone = '0;
      hmpRd  = 1'b0;
      total++;
      if (hmpValid !== 1'b1 || hmpAddr !== 7'd30 || bfFlag !== 1'b1) begin
         bad++; $display("[TB] FAIL ppe_push: got valid=%b addr=%0d flag=%b expected 1 30 1", hmpValid, hmpAddr, bfFlag);
      end
      hmpRd = 1'b1;
      tick();
      hmpRd = 1'b0;
      total++;
      if (hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL ppe_count: got valid=%b expected 0", hmpValid);
      end
   endtask

   task automatic test_overflow();
      int flagCount;
      flagCount = 0;
      // Pipelined: write cell i while releasing cell i-1 through port 0
      for (int i = 0; i <= 128; i++) begin
         wrEn      = (i < 128);
         cellAddr  = 7'(i);
         multicast = 4'b0001;
         rdDone[0] = (i > 0);
         rdAddr[6:0] = 7'(i - 1);
         tick();
         if (bfFlag === 1'b1) flagCount++;
      end
      idle();
      total++;
      if (flagCount !== 128) begin
         bad++; $display("[TB] FAIL ovf_fill_flags: got %0d expected 128", flagCount);
      end
      do_write(7'd0, 4'b0001);
      set_release(0, 7'd0);
      tick();
      rdDone = '0;
      total++;
      if (bfFlag !== 1'b0) begin
         bad++; $display("[TB] FAIL ovf_flag: got %b expected 0", bfFlag);
      end
      total++;
      if (err[2] !== ErrEn) begin
         bad++; $display("[TB] FAIL ovf_err: got %b expected %b", err[2], ErrEn);
      end
      for (int k = 0; k < 128; k++) begin
         total++;
         if (hmpValid !== 1'b1 || hmpAddr !== 7'(k)) begin
            bad++; $display("[TB] FAIL ovf_pop%0d: got valid=%b addr=%0d expected 1 %0d", k, hmpValid, hmpAddr, k);
         end
         hmpRd = 1'b1;
         tick();
      end
      hmpRd = 1'b0;
      total++;
      if (hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL ovf_count: got valid=%b expected 0", hmpValid);
      end
      // Both pointers have wrapped back to slot 0
      for (int i = 0; i <= 3; i++) begin
         wrEn      = (i < 3);
         cellAddr  = 7'(100 + i);
         multicast = 4'b0001;
         rdDone[0] = (i > 0);
         rdAddr[6:0] = 7'(99 + i);
         tick();
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         total++;
         if (hmpValid !== 1'b1 || hmpAddr !== 7'(100 + k)) begin
            bad++; $display("[TB] FAIL wrap_pop%0d: got valid=%b addr=%0d expected 1 %0d", k, hmpValid, hmpAddr, 100 + k);
         end
         hmpRd = 1'b1;
         tick();
      end
      hmpRd = 1'b0;
   endtask

   task automatic test_errors();
      logic [2:0] expErr;
      do_write(7'd7, 4'b0001);
      set_release(1, 7'd7);
      #1;
      total++;
      if (rdAck !== 4'b0010) begin
         bad++; $display("[TB] FAIL dbl_ack: got %b expected 0010", rdAck);
      end
      tick();
      rdDone = '0;
      total++;
      if (bfFlag !== 1'b0 || hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL dbl_nopush: got flag=%b valid=%b expected 0 0", bfFlag, hmpValid);
      end
      expErr = ErrEn ? 3'b110 : 3'b000;
      total++;
      if (err !== expErr) begin
         bad++; $display("[TB] FAIL dbl_err: got %b expected %b", err, expErr);
      end
      do_write(7'd8, 4'b0000);
      expErr = ErrEn ? 3'b111 : 3'b000;
      total++;
      if (err !== expErr) begin
         bad++; $display("[TB] FAIL zmw_err: got %b expected %b", err, expErr);
      end
      // Write and release on the same cell: the write must win
      set_release(1, 7'd9);
      do_write(7'd9, 4'b0010);
      rdDone = '0;
      total++;
      if (bfFlag !== 1'b0 || hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL coll_drop: got flag=%b valid=%b expected 0 0", bfFlag, hmpValid);
      end
      set_release(1, 7'd9);
      tick();
      rdDone = '0;
      total++;
      if (bfFlag !== 1'b1 || hmpValid !== 1'b1 || hmpAddr !== 7'd9) begin
         bad++; $display("[TB] FAIL coll_free: got flag=%b valid=%b addr=%0d expected 1 1 9", bfFlag, hmpValid, hmpAddr);
      end
      hmpRd = 1'b1;
      tick();
      hmpRd = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         do_write(7'(40 + i), 4'b0001);
         set_release(0, 7'(40 + i));
         tick();
         rdDone = '0;
      end
      do_write(7'd50, 4'b0001);
      total++;
      if (hmpValid !== 1'b1 || hmpAddr !== 7'd40) begin
         bad++; $display("[TB] FAIL rmid_pre: got valid=%b addr=%0d expected 1 40", hmpValid, hmpAddr);
      end
      rstN = 1'b0;
      tick();
      total++;
      if (hmpValid !== 1'b0 || hmpAddr !== 7'd0 || err !== 3'b000 || bfFlag !== 1'b0) begin
         bad++; $display("[TB] FAIL rmid_state: got valid=%b addr=%0d err=%b flag=%b expected 0 0 000 0", hmpValid, hmpAddr, err, bfFlag);
      end
      rstN = 1'b1;
      // Cell 50 had an outstanding bit before reset; it must be gone now
      set_release(0, 7'd50);
      tick();
      rdDone = '0;
      total++;
      if (bfFlag !== 1'b0 || hmpValid !== 1'b0) begin
         bad++; $display("[TB] FAIL rmid_mask: got flag=%b valid=%b expected 0 0", bfFlag, hmpValid);
      end
      do_write(7'd51, 4'b0100);
      set_release(2, 7'd51);
      tick();
      rdDone = '0;
      total++;
      if (bfFlag !== 1'b1 || hmpValid !== 1'b1 || hmpAddr !== 7'd51) begin
         bad++; $display("[TB] FAIL rmid_free: got flag=%b valid=%b addr=%0d expected 1 1 51", bfFlag, hmpValid, hmpAddr);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle();
      rstN = 1'b0;
      @(negedge clk);
      test_reset();
      test_multicast_release();
      test_round_robin();
      test_push_pop_empty();
      test_overflow();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hw_cell_free.md
Name: hw_cell_free

Overview:
- Release-side counterpart of the GSM cell allocator.
- Records the multicast reference mask of every cell written into shared memory.
- Collects per-egress-port "cell read done" reports and clears one mask bit per report.
- When a cell's mask reaches zero, pushes its address into the free-address FIFO that the allocator pops, and pulses the buffer-free flag to the allocator's available-cell counter.

Parameters:
MWIDTH, 4, number of egress ports (multicast vector width)
AWIDTH, 7, cell address width; 2**AWIDTH cells
LOG_MWIDTH, clogb(MWIDTH), port index width (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_gsm_wr_en  in  1  allocator wrote a cell this cycle
i_gsm_cell_addr  in  AWIDTH  address of written cell
i_gsm_multicast  in  MWIDTH  destination ports of written cell
i_rd_done  in  MWIDTH  per-port release request, level, held until acked
i_rd_addr  in  MWIDTH*AWIDTH  per-port released cell address, port p at [p*AWIDTH +: AWIDTH]
o_rd_ack  out  MWIDTH  one-hot grant, combinational, same cycle
i_hmp_rd  in  1  allocator pops free address
o_hmp_valid  out  1  free FIFO non-empty
o_hmp_addr  out  AWIDTH  FIFO head, first-word-fall-through
o_bf_free_flag  out  1  one-cycle pulse per freed cell
o_err  out  3  sticky {overflow, double_free, zero_mask_wr}

Behaviour:
- Reset (rst_n low at clk edge):
  - mask array cleared to 0.
  - FIFO empty; o_hmp_valid=0, o_hmp_addr=0.
  - o_bf_free_flag=0, o_err=0.
  - Arbiter pointer set to 0; o_rd_ack=0 while rst_n low.
  - Reset mid-operation discards all in-flight state. The FIFO restarts empty; the allocator re-seeds addresses from its init counter.
- Mask array: 2**AWIDTH x MWIDTH register file with combinational read.
- Allocator write: i_gsm_wr_en writes mask[addr] <= i_gsm_multicast at the clock edge.
- Release arbitration: round-robin over i_rd_done; at most one grant per cycle.
  - The pointer moves to (granted+1) mod MWIDTH after a grant and is unchanged with no request.
  - A port waits at most MWIDTH-1 cycles.
- Release in cycle N (port p, addr a):
  - new = mask[a] & ~(1<<p), written at edge N.
  - If new==0 and old!=0: push a into FIFO at edge N. o_bf_free_flag=1 during cycle N+1; o_hmp_valid=1 in N+1 if the FIFO was empty.
- Write and release in the same cycle, different addresses: both apply.
- Write and release in the same cycle, same address: write wins, release dropped, err zero_mask_wr not set; counts as double_free.
- FIFO:
  - Depth 2**AWIDTH, count AWIDTH+1 bits, binary pointers wrap at 2**AWIDTH.
  - Push and pop in the same cycle: both occur, count unchanged. If the FIFO is empty, the pop is ignored and the push proceeds.
  - Pop when empty: ignored.
  - Push when full: dropped, overflow set, o_bf_free_flag still suppressed.
- o_bf_free_flag: registered, asserted exactly once per successful push.

Optional Feature:
HW_CELL_FREE_ERR_CHK_EN
- Defined:
  - overflow detection as above.
  - double_free: release where bit p of mask[a] is already 0; mask unchanged, no push.
  - zero_mask_wr: i_gsm_wr_en with i_gsm_multicast==0; mask written 0, no push.
  - Bits are sticky until reset.
- Undefined: o_err tied 0 and no check logic. Double-free releases still clear nothing and never push. A push on full is still dropped.

Decomposition:
- Shared header alongside c_functions.v holds clogb and the error bit index constants: ERR_OVF=2, ERR_DBL=1, ERR_ZMW=0.
- One sub-module: hw_cell_free_rr_arb (MWIDTH-wide round-robin arbiter; req in, one-hot grant out, pointer register).
- FIFO stays inline.

Test Plan:
1. Write addr 5, mask 4'b0101. Release port0 addr5, then port2 addr5 → no push after first. After second: o_bf_free_flag=1 next cycle, o_hmp_valid=1, o_hmp_addr=5, and mask[5]=0.
2. All 4 ports request simultaneously, each releasing a distinct single-bit cell (addrs 10-13), pointer 0 → acks 0,1,2,3 in consecutive cycles. FIFO order 10,11,12,13; four flag pulses.
3. Empty FIFO, i_hmp_rd=1 with a push the same cycle → the push lands. Next cycle o_hmp_valid=1, count=1.
4. Fill 128 frees, then a 129th free → o_err[2]=1, count stays 128, no flag pulse. Wrap: pop 128 and push 3 → addresses come out in order.
5. With the macro: release port1 on addr 7, mask 4'b0001 → o_err[1]=1, no push. Write with mask 0 → o_err[0]=1. Without the macro: o_err=0.
6. Assert rst_n=0 for one cycle with FIFO holding 3 entries → o_hmp_valid=0, o_err=0, mask all zero. The next write/release pair frees normally.
